// File: rtl/alu.sv
// MCAV-9 8-bit ALU: combinational decode, every output registered one cycle after the operands.
// Define ALU_VTYPE_EN to build the Type 11 (POPCNT/REV) operations; otherwise Type 11 yields zero.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Type,
    input  logic [2:0] M_op,
    input  logic [1:0] C_op,
    input  logic [2:0] A_op,
    input  logic       V_op,
    input  logic [7:0] inA,
    input  logic [7:0] inB,
    input  logic       sc_i,
    output logic [7:0] rslt,
    output logic       sc_o,
    output logic       pari,
    output logic       zero
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic [W-1:0] rslt_q, r_d;
    logic         sc_q, c_d;
    logic         pari_q, zero_q;

    // Nine-bit sums shared by the arithmetic opcodes; bit W is the carry out.
    logic [W:0] add_c, sub_c, add_nc, inc_c;
    assign add_c  = {1'b0, inA} + {1'b0, inB} + (W+1)'(sc_i);
    assign sub_c  = {1'b0, inA} + {1'b0, ~inB} + (W+1)'(1);
    assign add_nc = {1'b0, inA} + {1'b0, inB};
    assign inc_c  = {1'b0, inA} + (W+1)'(1);

`ifdef ALU_VTYPE_EN
    logic [CW-1:0] pop;
    logic [W-1:0]  rev;
    always_comb begin
        pop = '0;
        rev = '0;
        for (int i = 0; i < int'(W); i++) begin
            pop        = pop + CW'(inA[i]);
            rev[W-1-i] = inA[i];
        end
    end
`else
    logic unused_vop;
    assign unused_vop = V_op;
`endif

    always_comb begin
        r_d = '0;
        c_d = 1'b0;
        unique case (Type)
            2'b00: begin
                unique case (M_op)
                    3'b000: {c_d, r_d} = add_c;
                    3'b001: {c_d, r_d} = sub_c;
                    3'b010: r_d = inA & inB;
                    3'b011: r_d = inA | inB;
                    3'b100: r_d = inA ^ inB;
                    3'b101: begin
                        r_d = {inA[W-2:0], sc_i};
                        c_d = inA[W-1];
                    end
                    3'b110: begin
                        r_d = {sc_i, inA[W-1:1]};
                        c_d = inA[0];
                    end
                    default: r_d = ~inA;
                endcase
            end
            2'b01: begin
                unique case (C_op)
                    2'b00:   c_d = (inA == inB);
                    2'b01:   c_d = (inA < inB);
                    2'b10:   c_d = (inA > inB);
                    default: c_d = ($signed(inA) < $signed(inB));
                endcase
                r_d = W'(c_d);
            end
            2'b10: begin
                unique case (A_op)
                    3'b000: r_d = inB;
                    3'b001: {c_d, r_d} = inc_c;
                    3'b010: begin
                        r_d = inA - W'(1);
                        c_d = (inA == '0);
                    end
                    3'b011: {c_d, r_d} = add_nc;
                    3'b100: r_d = {inA[W-2:0], inA[W-1]};
                    3'b101: r_d = {inA[0], inA[W-1:1]};
                    3'b110: r_d = {inA[3:0], inA[7:4]};
                    default: r_d = '0;
                endcase
            end
            default: begin
`ifdef ALU_VTYPE_EN
                r_d = V_op ? rev : W'(pop);
`else
                r_d = '0;
`endif
            end
        endcase
    end

    // Output registers; reset value presents a cleared, zero-flagged result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rslt_q <= '0;
            sc_q   <= 1'b0;
            pari_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            rslt_q <= r_d;
            sc_q   <= c_d;
            pari_q <= ^r_d;
            zero_q <= (r_d == '0);
        end
    end

    assign rslt = rslt_q;
    assign sc_o = sc_q;
    assign pari = pari_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; expected V-type results follow ALU_VTYPE_EN.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [1:0] Type;
    logic [2:0] M_op;
    logic [1:0] C_op;
    logic [2:0] A_op;
    logic       V_op;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       sc_i;
    logic [7:0] rslt;
    logic       sc_o;
    logic       pari;
    logic       zero;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Type (Type),
        .M_op (M_op),
        .C_op (C_op),
        .A_op (A_op),
        .V_op (V_op),
        .inA  (inA),
        .inB  (inB),
        .sc_i (sc_i),
        .rslt (rslt),
        .sc_o (sc_o),
        .pari (pari),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] er, input logic ec,
                           input logic ep, input logic ez);
        chk({tag, ".rslt"}, rslt, er);
        chk({tag, ".sc_o"}, 8'(sc_o), 8'(ec));
        chk({tag, ".pari"}, 8'(pari), 8'(ep));
        chk({tag, ".zero"}, 8'(zero), 8'(ez));
    endtask

    task automatic set_in(input logic [1:0] t, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic sc);
        Type = t;
        M_op = op;
        C_op = op[1:0];
        A_op = op;
        V_op = op[0];
        inA  = a;
        inB  = b;
        sc_i = sc;
    endtask

    // Apply one operation, clock it in, then check all four outputs.
    task automatic step(input string tag, input logic [1:0] t, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic sc,
                        input logic [7:0] er, input logic ec, input logic ep, input logic ez);
        set_in(t, op, a, b, sc);
        @(posedge clk);
        #1;
        chk_out(tag, er, ec, ep, ez);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(2'b00, 3'b000, 8'h5A, 8'h33, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_hold", 8'h00, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Math/logic class
        step("m_add",      2'b00, 3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
        step("m_add_wrap", 2'b00, 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step("m_add_ci",   2'b00, 3'b000, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0);
        step("m_sub_brw",  2'b00, 3'b001, 8'h01, 8'h03, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
        step("m_sub",      2'b00, 3'b001, 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0);
        step("m_and",      2'b00, 3'b010, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step("m_or",       2'b00, 3'b011, 8'hAA, 8'h55, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step("m_xor",      2'b00, 3'b100, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        step("m_shl",      2'b00, 3'b101, 8'h81, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        step("m_shr",      2'b00, 3'b110, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step("m_shr_ci",   2'b00, 3'b110, 8'h02, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        step("m_not",      2'b00, 3'b111, 8'h0F, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);

        // Compare class
        step("c_eq",       2'b01, 3'b000, 8'h05, 8'h05, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        step("c_ltu",      2'b01, 3'b001, 8'h01, 8'h09, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        step("c_ltu_no",   2'b01, 3'b001, 8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step("c_gtu_no",   2'b01, 3'b010, 8'h01, 8'h09, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step("c_lts",      2'b01, 3'b011, 8'h80, 8'h01, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);

        // Arith/move class; sc_i is set to show it is ignored here
        step("a_mov",      2'b10, 3'b000, 8'hFF, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step("a_inc_wrap", 2'b10, 3'b001, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        step("a_dec_zero", 2'b10, 3'b010, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step("a_dec",      2'b10, 3'b010, 8'h05, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0);
        step("a_add_nc",   2'b10, 3'b011, 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        step("a_rol",      2'b10, 3'b100, 8'h81, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        step("a_ror",      2'b10, 3'b101, 8'h01, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        step("a_swap",     2'b10, 3'b110, 8'hA5, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        step("a_clr",      2'b10, 3'b111, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        // Vector/bit class
`ifdef ALU_VTYPE_EN
        step("v_popcnt",   2'b11, 3'b000, 8'h0F, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
        step("v_rev",      2'b11, 3'b001, 8'h01, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
`else
        step("v_popcnt",   2'b11, 3'b000, 8'h0F, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step("v_rev",      2'b11, 3'b001, 8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

        // Inputs changing between edges must not disturb the registered outputs
        step("hold_ref",   2'b00, 3'b011, 8'h12, 8'h40, 1'b0, 8'h52, 1'b0, 1'b1, 1'b0);
        set_in(2'b10, 3'b111, 8'h00, 8'h00, 1'b0);
        #3;
        chk_out("hold_mid", 8'h52, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation discards it and holds while low
        @(posedge clk);
        #1;
        step("pre_rst",    2'b10, 3'b001, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        set_in(2'b00, 3'b000, 8'h10, 8'h20, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("rst_async", 8'h00, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk_out("rst_held", 8'h00, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        #1;
        chk_out("rst_rel", 8'h00, 1'b0, 1'b0, 1'b1);
        step("post_rst",   2'b00, 3'b000, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational-decode, registered-output 8-bit ALU for the MCAV-9 processor datapath. It takes two register operands (inA, inB) and a shift/carry input. It performs the operation selected by an instruction class (Type) and a per-class opcode. It drives the result and three status flags to the register file and branch logic one clock after the operands are presented.

## Interface
Parameters:
- none (datapath width fixed at 8 bits)

Ports:
- clk  in  1  clock; all outputs update on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Type  in  2  instruction class: 00 M (math/logic), 01 C (compare), 10 A (arith/move), 11 V (vector/bit)
- M_op  in  3  opcode when Type=00
- C_op  in  2  opcode when Type=01
- A_op  in  3  opcode when Type=10
- V_op  in  1  opcode when Type=11
- inA  in  8  operand A
- inB  in  8  operand B
- sc_i  in  1  shift/carry input
- rslt  out  8  registered result
- sc_o  out  1  registered shift/carry output
- pari  out  1  registered parity of rslt: XOR-reduce, 1 = odd number of ones
- zero  out  1  registered, 1 when rslt == 8'h00

## Operation
Next-state values r (8b) and c (1b) are computed combinationally. Unlisted cases give r=0, c=0.
- Type 00 (M):
  - 000 ADD: {c,r} = inA + inB + sc_i (9-bit)
  - 001 SUB: {c,r} = inA + ~inB + 1; c = 1 means no borrow
  - 010 AND; 011 OR; 100 XOR (c=0)
  - 101 SHL: r = {inA[6:0], sc_i}, c = inA[7]
  - 110 SHR: r = {sc_i, inA[7:1]}, c = inA[0]
  - 111 NOT: r = ~inA, c=0
- Type 01 (C): r = {7'b0, t}, c = t, where t is selected by C_op:
  - 00 inA==inB
  - 01 inA<inB unsigned
  - 10 inA>inB unsigned
  - 11 inA<inB signed
- Type 10 (A), c=0 except where noted:
  - 000 MOV: r = inB
  - 001 INC: r = inA+1, c = carry out
  - 010 DEC: r = inA-1, c = 1 when inA==0
  - 011 ADD without carry-in: r = inA+inB, c = carry out
  - 100 ROL: r = {inA[6:0], inA[7]}
  - 101 ROR: r = {inA[0], inA[7:1]}
  - 110 SWAP nibbles
  - 111 CLR: r = 0
- Type 11 (V):
  - V_op 0 POPCNT: r = number of ones in inA (0..8)
  - V_op 1 REV: r = bit-reverse of inA
  - c = 0 for both
- Flags are derived from r: pari = ^r, zero = (r==0).
- sc_i is ignored by all ops except M ADD, SHL and SHR.
- All arithmetic is modulo 256 apart from the carry bit.

## Timing
- At each rising edge of clk: rslt ← r, sc_o ← c, pari ← ^r, zero ← (r==0). Latency is one cycle; a new operation is accepted every cycle. There is no handshake.
- rst_n low immediately forces rslt=8'h00, sc_o=0, pari=0, zero=1, independent of clk.
  - This reset state is held while rst_n stays low.
  - The first capture after rst_n rises is at the next rising edge.
- Reset asserted in the middle of an operation discards that operation.
- Inputs that change between edges have no effect on the outputs until the next edge.

## Configuration
- ALU_VTYPE_EN defined: Type 11 operations are implemented as specified above.
- ALU_VTYPE_EN undefined: the V-type logic is not compiled. Type 11 produces r=0 and c=0, so zero=1 and pari=0 after the next edge.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs -> rslt=00, sc_o=0, pari=0, zero=1. Release reset, apply Type=00, M_op=000, inA=01, inB=01, sc_i=0 -> after one edge rslt=02, sc_o=0, pari=1, zero=0.
- ADD wrap: inA=FF, inB=01, sc_i=0 -> rslt=00, sc_o=1, zero=1. SUB with inA=01, inB=03 -> rslt=FE, sc_o=0.
- Logic: inA=AA, inB=55; AND -> rslt=00, zero=1; OR -> rslt=FF, pari=0; XOR -> rslt=FF.
- Shifts: SHL with inA=81, sc_i=1 -> rslt=03, sc_o=1. SHR with inA=01, sc_i=0 -> rslt=00, sc_o=1, zero=1.
- Compare: Type=01, C_op=01, inA=01, inB=09 -> rslt=01, sc_o=1. C_op=11, inA=80, inB=01 -> rslt=01.
- V-type: Type=11, V_op=0, inA=0F -> rslt=04 with ALU_VTYPE_EN, 00 without. V_op=1, inA=01 -> rslt=80 with ALU_VTYPE_EN.
